// File: rtl/sipo_rx_if.sv
// Parallel-side and serial-line signals of the sipo_rx frame receiver.
// master = line driver / consumer, slave = the receiver.
interface sipo_rx_if #(
   parameter int DATA_W = 8
);
   logic              En;
   logic              S_In;
   logic              Ack;
   logic [DATA_W-1:0] D_Out;
   logic              Valid;
   logic              Busy;
   logic              Frame_Err;
   logic              Overrun;

   modport master (
      output En, S_In, Ack,
      input  D_Out, Valid, Busy, Frame_Err, Overrun
   );

   modport slave (
      input  En, S_In, Ack,
      output D_Out, Valid, Busy, Frame_Err, Overrun
   );
endinterface

// File: rtl/sipo_rx.sv
// Serial-to-parallel frame receiver: start bit, DATA_W data bits LSB first,
// optional stop-bit check, one-word holding register with Valid/Ack handoff.
module sipo_rx #(
   parameter int DATA_W     = 8,
   parameter bit CHECK_STOP = 1'b1
) (
   input logic     CLK,
   input logic     RST,
   sipo_rx_if.slave bus
);
   localparam int                CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_STOP = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              ferr_q, ferr_d;
   logic              ovr_q, ovr_d;
   logic              done_s;
   logic [DATA_W-1:0] word_s;

   // Next-state logic: frame sequencing, then delivery into the holding register.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      done_s  = 1'b0;
      word_s  = shift_q;
      ferr_d  = 1'b0;
      dout_d  = dout_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;

      if (!bus.En) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         shift_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!bus.S_In) begin
                  state_d = ST_DATA;
                  cnt_d   = '0;
                  shift_d = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_DATA: begin
               shift_d[cnt_q] = bus.S_In;
               if (cnt_q == CNT_LAST) begin
                  cnt_d = '0;
                  if (CHECK_STOP) begin
                     state_d = ST_STOP;
                  end else begin
                     state_d = ST_IDLE;
                     done_s  = 1'b1;
                     word_s  = shift_d;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            ST_STOP: begin
               // A low stop bit drops the word and is never taken as a new start bit.
               state_d = ST_IDLE;
               if (bus.S_In) begin
                  done_s = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               shift_d = '0;
            end
         endcase
      end

      // Same-cycle Ack frees the holding register for the word completing now.
      if (done_s) begin
         if (!valid_q || bus.Ack) begin
            dout_d  = word_s;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (bus.Ack) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   assign bus.D_Out     = dout_q;
   assign bus.Valid     = valid_q;
   assign bus.Busy      = busy_q;
   assign bus.Frame_Err = ferr_q;
   assign bus.Overrun   = ovr_q;
endmodule

// File: doc/sipo_rx.md
# sipo_rx

Serial-to-parallel frame receiver that consumes the one-bit-per-clock stream produced by the team's PISO serializer: idle-high line, one start bit (0), DATA_W data bits LSB first, one stop bit (1). It recovers each byte into a holding register and presents it to the downstream parallel consumer through a Valid/Ack handshake. It also flags framing errors and overruns. It runs on the same CLK as the serializer with no oversampling.

## Interface
- DATA_W, 8: data bits per frame.
- CHECK_STOP, 1: 1 = sample and check the stop bit; 0 = frame completes after the last data bit.
- CLK  in  1  clock; all state changes on posedge.
- RST  in  1  reset, synchronous, active-low.
- En  in  1  receive enable; low aborts any in-flight frame (mirrors the serializer's Read).
- S_In  in  1  serial input, idle high.
- Ack  in  1  consumer accepts D_Out while Valid is high.
- D_Out  out  DATA_W  received word (holding register).
- Valid  out  1  D_Out holds an unacknowledged word.
- Busy  out  1  state is not IDLE.
- Frame_Err  out  1  one-cycle pulse on a bad stop bit.
- Overrun  out  1  sticky: a completed frame was dropped.

## Operation
- States:
  - IDLE: if S_In==0, go to DATA with bit counter = 0. Otherwise stay.
  - DATA: each cycle, shift S_In into bit position [counter]. Counter increments. When counter == DATA_W-1, go to STOP if CHECK_STOP=1, else complete and go to IDLE.
  - STOP: if S_In==1, complete and go to IDLE. If S_In==0, pulse Frame_Err, discard the word, and go to IDLE. This 0 is not reinterpreted as a start bit.
- Complete (in order of precedence):
  - Valid==0, or Ack==1 in the same cycle: load D_Out; Valid=1.
  - Otherwise: keep the old D_Out; set Overrun=1. The new word is lost.
- Handshake:
  - Valid stays high until a cycle with Ack==1.
  - Ack with Valid==0 is ignored.
  - Ack and completion in the same cycle: the new word replaces the old one, Valid stays 1, Overrun is unchanged.
- Back-to-back frames: in IDLE, the cycle directly after completion may hold the next start bit.
- En==0 (with RST high): return to IDLE next cycle, clear the shift register and counter. D_Out, Valid and Overrun are unaffected. A frame cannot start while En==0.
- Overrun clears only on RST.
- Bit-width rule: the counter is sized to ceil(log2(DATA_W)) bits and never wraps past DATA_W-1.

## Timing
- RST low at a posedge sets next-cycle values:
  - state IDLE, counter 0, shift register 0
  - D_Out 0, Valid 0, Busy 0, Frame_Err 0, Overrun 0
- RST has priority over En, Ack and S_In. Reset mid-frame discards the frame.
- Start bit sampled at edge t:
  - data bit i is sampled at edge t+1+i
  - CHECK_STOP=1: stop bit sampled at t+DATA_W+1; Valid high after edge t+DATA_W+1 (DATA_W=8: sampled at t+9, Valid visible in cycle t+10)
  - CHECK_STOP=0: Valid visible one cycle earlier
- Frame_Err is high for exactly the one cycle following the bad stop sample.
- Busy is high from the cycle after the start sample through the cycle containing the final sample.
- Throughput: one frame per DATA_W+2 cycles, with no idle gap required.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Single frame: reset, En=1, S_In stream 1,1,0,1,0,1,0,0,1,0,1,1 (0xA5 LSB first, stop 1) -> Valid rises 10 cycles after the start sample, D_Out=0xA5, Frame_Err=0. Ack for 1 cycle -> Valid=0 next cycle.
- Back-to-back: frames 0x3C then 0xC3 with no idle gap; Ack is pulsed when the first Valid appears -> both words delivered in order, Overrun=0.
- Overrun: two frames 0x11 and 0x22, Ack never asserted -> D_Out stays 0x11, Valid=1, Overrun=1 after the second frame completes. Ack in the same cycle as the second completion instead -> D_Out=0x22, Overrun=0.
- Framing error: frame 0x5A with stop bit 0, followed by an idle line -> Frame_Err pulses for 1 cycle, Valid stays 0, state returns to IDLE. A clean 0x5A frame afterwards is received correctly.
- Abort/reset: En dropped low during data bit 4 of frame 0xFF -> Busy=0 next cycle, no Valid. RST low during a frame while Valid=1 and Overrun=1 -> all outputs are 0 next cycle.
- Parameter sweep: DATA_W=5, CHECK_STOP=0, frame 0x15 -> Valid is visible 6 cycles after the start sample, D_Out=5'h15.
